dmaio: RTL and testbench

- Memory-to-memory DMA initiator for the 6801 system bus.
- Sits in the $E6xx I/O window as a normal register-mapped responder on the CPU side.
- While a transfer runs it asserts hold to freeze cpu68 and takes over the address, data and rw lines.
- It is the initiator counterpart to the bus's responder peripherals. It drives external SRAM, block RAM and I/O through the same top-level bus mux.

---
 rtl/dmaio_pkg.sv | 32 +++
 rtl/dmaio.sv | 213 +++++++++++++++++++++
 tb/tb_dmaio.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmaio_pkg.sv
// Shared constants for the dmaio memory-to-memory DMA initiator.
// Register offsets, CTRL/STATUS bit positions and FSM state encoding.
package dmaio_pkg;

    localparam logic [2:0] REG_SRC_H  = 3'd0;
    localparam logic [2:0] REG_SRC_L  = 3'd1;
    localparam logic [2:0] REG_DST_H  = 3'd2;
    localparam logic [2:0] REG_DST_L  = 3'd3;
    localparam logic [2:0] REG_LEN_H  = 3'd4;
    localparam logic [2:0] REG_LEN_L  = 3'd5;
    localparam logic [2:0] REG_CTRL   = 3'd6;
    localparam logic [2:0] REG_STATUS = 3'd7;

    localparam int unsigned CTRL_START   = 0;
    localparam int unsigned CTRL_SRC_INC = 1;
    localparam int unsigned CTRL_DST_INC = 2;
    localparam int unsigned CTRL_IRQ_EN  = 3;
    localparam int unsigned CTRL_ABORT   = 7;

    localparam int unsigned STAT_DONE    = 0;
    localparam int unsigned STAT_ABORTED = 1;
    localparam int unsigned STAT_BUSY    = 7;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSettle = 3'd1,
        StRd     = 3'd2,
        StWr     = 3'd3,
        StDone   = 3'd4
    } state_e;

endpackage

// File: rtl/dmaio.sv
// DMA initiator on the 6801 bus: register-mapped on the CPU side, takes the bus via hold
// and copies LEN bytes from SRC to DST at two clocks per byte.
module dmaio
    import dmaio_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  AD,
    input  logic [7:0]  DI,
    output logic [7:0]  DO,
    input  logic        rw,
    input  logic        cs,
    output logic        irq,
    output logic        hold,
    output logic        dma_en,
    output logic [15:0] dma_ad,
    output logic        dma_rw,
    output logic        dma_vma,
    output logic [7:0]  dma_do,
    input  logic [7:0]  dma_di
);

    localparam logic [1:0] SettleLast = 2'(SETTLE - 1);

    state_e      state_q, state_d;
    logic [15:0] src_q, src_d, dst_q, dst_d, len_q, len_d;
    logic        src_inc_q, src_inc_d, dst_inc_q, dst_inc_d, irq_en_q, irq_en_d;
    logic        done_q, done_d, aborted_q, aborted_d, abort_pend_q, abort_pend_d;
    logic        irq_q, irq_d, hold_q, hold_d, dma_en_q, dma_en_d;
    logic        dma_vma_q, dma_vma_d, dma_rw_q, dma_rw_d;
    logic [15:0] dma_ad_q, dma_ad_d;
    logic [7:0]  dma_do_q, dma_do_d;
    logic [1:0]  cnt_q, cnt_d;

    logic busy, wr_en, ctrl_wr, start_w, abort_w, status_wr;

    assign busy      = (state_q != StIdle);
    assign wr_en     = cs & ~rw;
    assign ctrl_wr   = wr_en && (AD == REG_CTRL);
    assign start_w   = ctrl_wr && DI[CTRL_START];
    assign abort_w   = ctrl_wr && DI[CTRL_ABORT];
    assign status_wr = wr_en && (AD == REG_STATUS);

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        len_d        = len_q;
        src_inc_d    = src_inc_q;
        dst_inc_d    = dst_inc_q;
        irq_en_d     = irq_en_q;
        done_d       = done_q;
        aborted_d    = aborted_q;
        abort_pend_d = abort_pend_q;
        irq_d        = irq_q;
        cnt_d        = cnt_q;
        dma_ad_d     = dma_ad_q;
        dma_do_d     = dma_do_q;

        if (wr_en && !busy) begin
            case (AD)
                REG_SRC_H: src_d[15:8] = DI;
                REG_SRC_L: src_d[7:0]  = DI;
                REG_DST_H: dst_d[15:8] = DI;
                REG_DST_L: dst_d[7:0]  = DI;
                REG_LEN_H: len_d[15:8] = DI;
                REG_LEN_L: len_d[7:0]  = DI;
                REG_CTRL: begin
                    src_inc_d = DI[CTRL_SRC_INC];
                    dst_inc_d = DI[CTRL_DST_INC];
                    irq_en_d  = DI[CTRL_IRQ_EN];
                end
                default: ;
            endcase
        end

        if (status_wr) begin
            done_d    = 1'b0;
            aborted_d = 1'b0;
            irq_d     = 1'b0;
        end

        case (state_q)
            StIdle: begin
                // ABORT in the same write suppresses START
                if (start_w && !abort_w) begin
                    done_d       = 1'b0;
                    aborted_d    = 1'b0;
                    abort_pend_d = 1'b0;
                    if (len_q != 16'd0) begin
                        state_d = StSettle;
                        cnt_d   = SettleLast;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StSettle: begin
                if (abort_w) begin
                    state_d      = StDone;
                    abort_pend_d = 1'b1;
                end else if (cnt_q == 2'd0) begin
                    state_d = StRd;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            StRd: begin
                if (abort_w) begin
                    state_d      = StDone;
                    abort_pend_d = 1'b1;
                end else begin
                    dma_do_d = dma_di;
                    state_d  = StWr;
                end
            end
            StWr: begin
                len_d = len_q - 16'd1;
                if (src_inc_q) src_d = src_q + 16'd1;
                if (dst_inc_q) dst_d = dst_q + 16'd1;
                if (abort_w || len_d == 16'd0) begin
                    state_d      = StDone;
                    abort_pend_d = abort_w;
                end else begin
                    state_d = StRd;
                end
            end
            StDone: begin
                done_d    = 1'b1;
                aborted_d = abort_pend_q;
                if (irq_en_q) irq_d = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Bus outputs are registered from the next state so they line up with it.
        hold_d    = state_d inside {StSettle, StRd, StWr};
        dma_en_d  = state_d inside {StRd, StWr};
        dma_vma_d = dma_en_d;
        dma_rw_d  = (state_d != StWr);
        if (state_d == StRd) dma_ad_d = src_d;
        if (state_d == StWr) dma_ad_d = dst_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            src_inc_q    <= 1'b0;
            dst_inc_q    <= 1'b0;
            irq_en_q     <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            irq_q        <= 1'b0;
            cnt_q        <= '0;
            hold_q       <= 1'b0;
            dma_en_q     <= 1'b0;
            dma_vma_q    <= 1'b0;
            dma_rw_q     <= 1'b1;
            dma_ad_q     <= '0;
            dma_do_q     <= '0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            len_q        <= len_d;
            src_inc_q    <= src_inc_d;
            dst_inc_q    <= dst_inc_d;
            irq_en_q     <= irq_en_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            abort_pend_q <= abort_pend_d;
            irq_q        <= irq_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            dma_en_q     <= dma_en_d;
            dma_vma_q    <= dma_vma_d;
            dma_rw_q     <= dma_rw_d;
            dma_ad_q     <= dma_ad_d;
            dma_do_q     <= dma_do_d;
        end
    end

    always_comb begin
        DO = 8'h00;
        case (AD)
            REG_SRC_H:  DO = src_q[15:8];
            REG_SRC_L:  DO = src_q[7:0];
            REG_DST_H:  DO = dst_q[15:8];
            REG_DST_L:  DO = dst_q[7:0];
            REG_LEN_H:  DO = len_q[15:8];
            REG_LEN_L:  DO = len_q[7:0];
            REG_CTRL:   DO = {4'b0000, irq_en_q, dst_inc_q, src_inc_q, 1'b0};
            REG_STATUS: DO = {busy, 5'b00000, aborted_q, done_q};
            default:    DO = 8'h00;
        endcase
    end

    assign irq     = irq_q;
    assign hold    = hold_q;
    assign dma_en  = dma_en_q;
    assign dma_vma = dma_vma_q;
    assign dma_rw  = dma_rw_q;
    assign dma_ad  = dma_ad_q;
    assign dma_do  = dma_do_q;

endmodule

// File: tb/tb_dmaio.sv
// Directed bench for dmaio: register access table plus hand-built transfer sequences
// against a 64 KiB byte-array bus model.
module tb_dmaio;
    import dmaio_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  AD = 3'd0;
    logic [7:0]  DI = 8'h00;
    logic [7:0]  DO;
    logic        rw = 1'b1;
    logic        cs = 1'b0;
    logic        irq, hold, dma_en, dma_rw, dma_vma;
    logic [15:0] dma_ad;
    logic [7:0]  dma_do, dma_di;

    logic [7:0]  mem [0:65535];
    logic [15:0] rd_log[$];
    logic [15:0] wr_log[$];
    int          hold_total = 0;
    int          errors = 0;
    int          checks = 0;

    dmaio #(.SETTLE(1)) dut (
        .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs), .irq(irq),
        .hold(hold), .dma_en(dma_en), .dma_ad(dma_ad), .dma_rw(dma_rw), .dma_vma(dma_vma),
        .dma_do(dma_do), .dma_di(dma_di)
    );

    always #5 clk = ~clk;

    assign dma_di = mem[dma_ad];

    always @(posedge clk) begin
        if (hold) hold_total <= hold_total + 1;
        if (dma_en && dma_vma && dma_rw) rd_log.push_back(dma_ad);
        if (dma_en && dma_vma && !dma_rw) begin
            mem[dma_ad] = dma_do;
            wr_log.push_back(dma_ad);
        end
    end

    typedef struct {
        logic       wr;
        logic [2:0] ad;
        logic [7:0] d;
    } vec_t;

    vec_t vecs [0:19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        AD = a; DI = d; rw = 1'b0; cs = 1'b1;
        @(posedge clk);
        #1;
        cs = 1'b0; rw = 1'b1;
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [7:0] d);
        AD = a; rw = 1'b1; cs = 1'b1;
        #1;
        d = DO;
        cs = 1'b0;
    endtask

    task automatic setup(input logic [15:0] s, input logic [15:0] t, input logic [15:0] l);
        cpu_write(REG_SRC_H, s[15:8]);
        cpu_write(REG_SRC_L, s[7:0]);
        cpu_write(REG_DST_H, t[15:8]);
        cpu_write(REG_DST_L, t[7:0]);
        cpu_write(REG_LEN_H, l[15:8]);
        cpu_write(REG_LEN_L, l[7:0]);
    endtask

    // Cycles from the START edge until STATUS.BUSY reads 0.
    task automatic wait_idle(output int n);
        n = 0;
        AD = REG_STATUS; rw = 1'b1; cs = 1'b1;
        #1;
        while (DO[STAT_BUSY] && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        cs = 1'b0;
        if (n >= 1000) chk("busy_timeout", 32'(n), 32'd0);
    endtask

    task automatic rd16(input logic [2:0] hi, output logic [15:0] v);
        logic [7:0] h, l;
        cpu_read(hi, h);
        cpu_read(hi + 3'd1, l);
        v = {h, l};
    endtask

    logic [7:0]  r8;
    logic [15:0] r16;
    int          n, h0, rs, ws;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        for (int i = 0; i < 8; i++) vecs[i] = '{1'b0, 3'(i), 8'h00};
        vecs[8]  = '{1'b1, REG_SRC_H, 8'hAB};
        vecs[9]  = '{1'b1, REG_SRC_L, 8'hCD};
        vecs[10] = '{1'b1, REG_DST_H, 8'h12};
        vecs[11] = '{1'b1, REG_LEN_L, 8'h78};
        vecs[12] = '{1'b1, REG_CTRL,  8'h0E};
        vecs[13] = '{1'b0, REG_SRC_H, 8'hAB};
        vecs[14] = '{1'b0, REG_SRC_L, 8'hCD};
        vecs[15] = '{1'b0, REG_DST_H, 8'h12};
        vecs[16] = '{1'b0, REG_LEN_L, 8'h78};
        vecs[17] = '{1'b0, REG_CTRL,  8'h0E};
        vecs[18] = '{1'b1, REG_CTRL,  8'h80};
        vecs[19] = '{1'b0, REG_STATUS, 8'h00};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_hold", 32'(hold), 32'd0);
        chk("rst_dma_en", 32'(dma_en), 32'd0);
        chk("rst_dma_vma", 32'(dma_vma), 32'd0);
        chk("rst_dma_rw", 32'(dma_rw), 32'd1);
        chk("rst_dma_ad", 32'(dma_ad), 32'd0);
        chk("rst_dma_do", 32'(dma_do), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);

        for (int i = 0; i < 20; i++) begin
            if (vecs[i].wr) cpu_write(vecs[i].ad, vecs[i].d);
            else begin
                cpu_read(vecs[i].ad, r8);
                chk($sformatf("vec%0d_reg%0d", i, vecs[i].ad), 32'(r8), 32'(vecs[i].d));
            end
        end
        cpu_read(REG_CTRL, r8);
        chk("abort_idle_ctrl", 32'(r8), 32'h00);

        // Basic incrementing copy
        mem[16'h1000] = 8'h11; mem[16'h1001] = 8'h22;
        mem[16'h1002] = 8'h33; mem[16'h1003] = 8'h44;
        setup(16'h1000, 16'h2000, 16'd4);
        h0 = hold_total;
        cpu_write(REG_CTRL, 8'h07);
        wait_idle(n);
        chk("copy_latency", 32'(n), 32'd10);
        chk("copy_hold_cycles", 32'(hold_total - h0), 32'd9);
        for (int i = 0; i < 4; i++)
            chk($sformatf("copy_mem%0d", i), 32'(mem[16'h2000 + i]), 32'(8'h11 * (i + 1)));
        rd16(REG_SRC_H, r16); chk("copy_src", 32'(r16), 32'h1004);
        rd16(REG_DST_H, r16); chk("copy_dst", 32'(r16), 32'h2004);
        rd16(REG_LEN_H, r16); chk("copy_len", 32'(r16), 32'h0000);
        cpu_read(REG_STATUS, r8); chk("copy_status", 32'(r8), 32'h01);
        chk("copy_irq", 32'(irq), 32'd0);

        // Fill mode
        mem[16'h3000] = 8'hA5; mem[16'h3001] = 8'h5A;
        setup(16'h3000, 16'h4000, 16'd3);
        rs = rd_log.size();
        cpu_write(REG_CTRL, 8'h05);
        wait_idle(n);
        chk("fill_latency", 32'(n), 32'd8);
        for (int i = 0; i < 3; i++)
            chk($sformatf("fill_mem%0d", i), 32'(mem[16'h4000 + i]), 32'hA5);
        chk("fill_reads", 32'(rd_log.size() - rs), 32'd3);
        for (int i = rs; i < rd_log.size(); i++)
            chk($sformatf("fill_rdaddr%0d", i - rs), 32'(rd_log[i]), 32'h3000);
        rd16(REG_SRC_H, r16); chk("fill_src", 32'(r16), 32'h3000);

        // Address wrap
        mem[16'hFFFE] = 8'hC1; mem[16'hFFFF] = 8'hC2; mem[16'h0000] = 8'hC3;
        setup(16'hFFFE, 16'h0100, 16'd3);
        rs = rd_log.size();
        cpu_write(REG_CTRL, 8'h07);
        wait_idle(n);
        chk("wrap_reads", 32'(rd_log.size() - rs), 32'd3);
        if (rd_log.size() - rs == 3) begin
            chk("wrap_rd0", 32'(rd_log[rs]), 32'hFFFE);
            chk("wrap_rd1", 32'(rd_log[rs + 1]), 32'hFFFF);
            chk("wrap_rd2", 32'(rd_log[rs + 2]), 32'h0000);
        end
        chk("wrap_mem0", 32'(mem[16'h0100]), 32'hC1);
        chk("wrap_mem2", 32'(mem[16'h0102]), 32'hC3);
        rd16(REG_SRC_H, r16); chk("wrap_src", 32'(r16), 32'h0001);

        // Completion interrupt and STATUS clear
        setup(16'h1000, 16'h5000, 16'd1);
        cpu_write(REG_CTRL, 8'h0F);
        wait_idle(n);
        chk("irq_latency", 32'(n), 32'd4);
        chk("irq_set", 32'(irq), 32'd1);
        cpu_write(REG_STATUS, 8'h00);
        chk("irq_cleared", 32'(irq), 32'd0);
        cpu_read(REG_STATUS, r8); chk("irq_status_clr", 32'(r8), 32'h00);

        // Abort mid-transfer: abort edge lands at the end of an RD cycle
        setup(16'h5000, 16'h6000, 16'd100);
        ws = wr_log.size();
        cpu_write(REG_CTRL, 8'h07);
        repeat (9) @(posedge clk);
        cpu_write(REG_CTRL, 8'h80);
        chk("abort_hold_drop", 32'(hold), 32'd0);
        wait_idle(n);
        chk("abort_writes", 32'(wr_log.size() - ws), 32'd4);
        rd16(REG_LEN_H, r16);
        chk("abort_len", 32'(r16), 32'(100 - (wr_log.size() - ws)));
        chk("abort_len_abs", 32'(r16), 32'd96);
        rd16(REG_SRC_H, r16); chk("abort_src", 32'(r16), 32'h5004);
        cpu_read(REG_STATUS, r8); chk("abort_status", 32'(r8), 32'h03);
        ws = wr_log.size();
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_late_wr", 32'(wr_log.size() - ws), 32'd0);

        // LEN=0 goes straight to DONE without hold
        cpu_write(REG_STATUS, 8'h00);
        setup(16'h1000, 16'h7000, 16'd0);
        h0 = hold_total;
        cpu_write(REG_CTRL, 8'h07);
        wait_idle(n);
        chk("len0_latency", 32'(n), 32'd1);
        chk("len0_no_hold", 32'(hold_total - h0), 32'd0);
        cpu_read(REG_STATUS, r8); chk("len0_status", 32'(r8), 32'h01);

        // START and ABORT together: nothing starts
        cpu_write(REG_STATUS, 8'h00);
        setup(16'h1000, 16'h7000, 16'd2);
        cpu_write(REG_CTRL, 8'h87);
        cpu_read(REG_STATUS, r8); chk("startabort_status", 32'(r8), 32'h00);
        @(posedge clk); #1;
        chk("startabort_hold", 32'(hold), 32'd0);

        // Reset during a WR cycle
        setup(16'h1000, 16'h7100, 16'd5);
        cpu_write(REG_CTRL, 8'h07);
        n = 0;
        while (!(dma_en && !dma_rw) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rstwr_found_wr", 32'(n < 50), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstwr_hold", 32'(hold), 32'd0);
        chk("rstwr_dma_en", 32'(dma_en), 32'd0);
        chk("rstwr_dma_rw", 32'(dma_rw), 32'd1);
        chk("rstwr_dma_ad", 32'(dma_ad), 32'd0);
        for (int i = 0; i < 8; i++) begin
            cpu_read(3'(i), r8);
            chk($sformatf("rstwr_reg%0d", i), 32'(r8), 32'h00);
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
